// File: rtl/systolic_pkg.sv
// Shared types and constants for the 2x2 systolic array feeder.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD0,
    LOAD1,
    STREAM,
    DRAIN
  } state_t;

  localparam int unsigned DRAIN_CYCLES = 4;
  localparam int unsigned SKEW         = 1;
  localparam int unsigned COL1_LAT     = 3;
  localparam int unsigned COL2_LAT     = 4;
  localparam int unsigned DRAIN_CNT_W  = $clog2(DRAIN_CYCLES);

  // Field positions inside w_data / act_data, in units of DATA_WIDTH.
  localparam int unsigned W00_FIELD = 0;
  localparam int unsigned W01_FIELD = 1;
  localparam int unsigned W10_FIELD = 2;
  localparam int unsigned W11_FIELD = 3;
  localparam int unsigned X0_FIELD  = 0;
  localparam int unsigned X1_FIELD  = 1;

endpackage

// File: rtl/skew_delay.sv
// Data+valid delay line; a bubble (vin=0) travels as zero data.
module skew_delay #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             vin,
  output logic [WIDTH-1:0] dout,
  output logic             vout
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            valid_q;

  // Shift data and valid one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q[0]  <= vin ? din : '0;
      valid_q[0] <= vin;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign dout = data_q[DEPTH-1];
  assign vout = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Weight load + skewed activation feed for the 2x2 weight-stationary array.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*DATA_WIDTH-1:0] w_data,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [2*DATA_WIDTH-1:0] act_data,
  input  logic                    act_valid,
  input  logic                    act_last,
  output logic                    act_ready,
  output logic [DATA_WIDTH-1:0]   top_1,
  output logic [DATA_WIDTH-1:0]   top_2,
  output logic [DATA_WIDTH-1:0]   left_1,
  output logic [DATA_WIDTH-1:0]   left_2,
  output logic                    WE_1,
  output logic                    WE_2,
  output logic                    WE_3,
  output logic                    WE_4,
  output logic                    mux_1,
  output logic                    mux_2,
  output logic                    mux_3,
  output logic                    mux_4,
  output logic                    col1_valid,
  output logic                    col2_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned DW = DATA_WIDTH;

  state_t                 state;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic [DW-1:0]          w00_q, w01_q;
  logic                   we_q, mux_q;

  logic [DW-1:0] w00_in, w01_in, w10_in, w11_in, x0_in, x1_in;
  logic          w_hs, act_hs;
  logic          col1_last;
  logic          unused_row2_v, unused_col2_last;

  assign w00_in = w_data[W00_FIELD*DW +: DW];
  assign w01_in = w_data[W01_FIELD*DW +: DW];
  assign w10_in = w_data[W10_FIELD*DW +: DW];
  assign w11_in = w_data[W11_FIELD*DW +: DW];
  assign x0_in  = act_data[X0_FIELD*DW +: DW];
  assign x1_in  = act_data[X1_FIELD*DW +: DW];

  // w_ready/act_ready are only ever high in IDLE/STREAM, so these are state-qualified.
  assign w_hs   = w_valid && w_ready;
  assign act_hs = act_valid && act_ready;

  assign {WE_1, WE_2, WE_3, WE_4}     = {4{we_q}};
  assign {mux_1, mux_2, mux_3, mux_4} = {4{mux_q}};

  // Control FSM; every output is set for the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      w00_q     <= '0;
      w01_q     <= '0;
      top_1     <= '0;
      top_2     <= '0;
      left_1    <= '0;
      we_q      <= 1'b0;
      mux_q     <= 1'b0;
      w_ready   <= 1'b0;
      act_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done   <= 1'b0;
      left_1 <= act_hs ? x0_in : '0;
      unique case (state)
        IDLE: begin
          w_ready <= 1'b1;
          if (w_hs) begin
            // Row-2 weights go first: they must ripple through PE one/three.
            w00_q   <= w00_in;
            w01_q   <= w01_in;
            top_1   <= w10_in;
            top_2   <= w11_in;
            w_ready <= 1'b0;
            busy    <= 1'b1;
            state   <= LOAD0;
          end
        end
        LOAD0: begin
          top_1 <= w00_q;
          top_2 <= w01_q;
          we_q  <= 1'b1;
          state <= LOAD1;
        end
        LOAD1: begin
          top_1     <= '0;
          top_2     <= '0;
          we_q      <= 1'b0;
          mux_q     <= 1'b1;
          act_ready <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          if (act_hs && act_last) begin
            act_ready <= 1'b0;
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_CNT_W'(DRAIN_CYCLES - 1)) begin
            mux_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            w_ready <= 1'b1;
            state   <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row 2 lags row 1 by SKEW cycles; the extra stage is the output register.
  skew_delay #(.WIDTH(DW), .DEPTH(SKEW + 1)) u_row2_skew (
    .clk   (clk),
    .rst_n (reset),
    .din   (x1_in),
    .vin   (act_hs),
    .dout  (left_2),
    .vout  (unused_row2_v)
  );

  // Column valids; the end-of-stream marker rides along with them.
  skew_delay #(.WIDTH(1), .DEPTH(COL1_LAT)) u_col1_pipe (
    .clk   (clk),
    .rst_n (reset),
    .din   (act_last),
    .vin   (act_hs),
    .dout  (col1_last),
    .vout  (col1_valid)
  );

  skew_delay #(.WIDTH(1), .DEPTH(COL2_LAT - COL1_LAT)) u_col2_pipe (
    .clk   (clk),
    .rst_n (reset),
    .din   (col1_last),
    .vin   (col1_valid),
    .dout  (unused_col2_last),
    .vout  (col2_valid)
  );

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench: feeder drives a behavioural 2x2 weight-stationary array.
module tb_systolic_feeder;

  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [4*DW-1:0] w_data;
  logic            w_valid;
  logic            w_ready;
  logic [2*DW-1:0] act_data;
  logic            act_valid, act_last, act_ready;
  logic [DW-1:0]   top_1, top_2, left_1, left_2;
  logic            WE_1, WE_2, WE_3, WE_4;
  logic            mux_1, mux_2, mux_3, mux_4;
  logic            col1_valid, col2_valid, busy, done;

  systolic_feeder #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .act_data(act_data), .act_valid(act_valid), .act_last(act_last), .act_ready(act_ready),
    .top_1(top_1), .top_2(top_2), .left_1(left_1), .left_2(left_2),
    .WE_1(WE_1), .WE_2(WE_2), .WE_3(WE_3), .WE_4(WE_4),
    .mux_1(mux_1), .mux_2(mux_2), .mux_3(mux_3), .mux_4(mux_4),
    .col1_valid(col1_valid), .col2_valid(col2_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Downstream array: PE one (w00) / three (w01) on row 1, two (w10) / four (w11) on row 2.
  logic [DW-1:0] p1_w, p1_d, p1_r, p3_w, p3_d;
  logic [DW-1:0] p2_w, p2_d, p2_r, p4_w, p4_d;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      {p1_w, p1_d, p1_r, p3_w, p3_d} <= '0;
      {p2_w, p2_d, p2_r, p4_w, p4_d} <= '0;
    end else begin
      if (WE_1) p1_w <= top_1;
      if (WE_3) p3_w <= top_2;
      if (WE_2) p2_w <= p1_d;
      if (WE_4) p4_w <= p3_d;
      p1_d <= mux_1 ? DW'(top_1 + p1_w * left_1) : top_1;
      p3_d <= mux_3 ? DW'(top_2 + p3_w * p1_r)   : top_2;
      p2_d <= mux_2 ? DW'(p1_d + p2_w * left_2)  : p1_d;
      p4_d <= mux_4 ? DW'(p3_d + p4_w * p2_r)    : p3_d;
      p1_r <= left_1;
      p2_r <= left_2;
    end
  end

  // Scoreboard state: expected values keyed by the edge after which they appear.
  typedef struct { int cyc; logic [DW-1:0] val; } exp_t;
  exp_t          q1[$], q2[$];
  logic [DW-1:0] exp_l1[int], exp_l2[int];
  int            exp_done = -1;
  logic [DW-1:0] cw00, cw01, cw10, cw11;

  // Monitor: compares feed data, column results and done against the scoreboard.
  always @(negedge clk) begin : monitor
    bit due1, due2;
    if (reset === 1'b1) begin
      check("left_1", left_1, exp_l1.exists(ecnt) ? exp_l1[ecnt] : '0);
      check("left_2", left_2, exp_l2.exists(ecnt) ? exp_l2[ecnt] : '0);
      check("done", done, ecnt == exp_done);
      due1 = (q1.size() != 0) && (q1[0].cyc == ecnt);
      due2 = (q2.size() != 0) && (q2[0].cyc == ecnt);
      check("col1_valid", col1_valid, due1);
      check("col2_valid", col2_valid, due2);
      if (due1 && col1_valid) check("down_1", p2_d, q1[0].val);
      if (due2 && col2_valid) check("down_2", p4_d, q2[0].val);
      while (q1.size() != 0 && q1[0].cyc <= ecnt) void'(q1.pop_front());
      while (q2.size() != 0 && q2[0].cyc <= ecnt) void'(q2.pop_front());
    end
  end

  task automatic clear_scoreboard();
    q1.delete(); q2.delete();
    exp_l1.delete(); exp_l2.delete();
    exp_done = -1;
  endtask

  task automatic check_outputs(input string name, input logic [13:0] ctrl_exp);
    check({name, "_data"}, {top_1, top_2, left_1, left_2}, '0);
    check({name, "_ctrl"}, {WE_1, WE_2, WE_3, WE_4, mux_1, mux_2, mux_3, mux_4,
                            col1_valid, col2_valid, busy, done, w_ready, act_ready}, ctrl_exp);
  endtask

  // Offer a weight set (called at a falling edge) and follow it through the load cycles.
  task automatic load(input logic [DW-1:0] a00, a01, a10, a11, input bit at_done);
    int guard = 0;
    w_data  = {a11, a10, a01, a00};
    w_valid = 1'b1;
    while (w_ready !== 1'b1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("w_ready_wait", w_ready, 1'b1);
    if (at_done) check("accept_in_done_cycle", done, 1'b1);
    cw00 = a00; cw01 = a01; cw10 = a10; cw11 = a11;
    @(negedge clk);
    w_valid    = 1'b0;
    act_valid  = 1'b1;
    act_last   = 1'b1;
    act_data   = $urandom;
    check("load0_top_1", top_1, a10);
    check("load0_top_2", top_2, a11);
    check("load0_we_mux", {WE_1, WE_2, WE_3, WE_4, mux_1, mux_2, mux_3, mux_4}, '0);
    check("load0_rdy_busy", {w_ready, act_ready, busy}, 3'b001);
    @(negedge clk);
    check("load1_top_1", top_1, a00);
    check("load1_top_2", top_2, a01);
    check("load1_we_mux", {WE_1, WE_2, WE_3, WE_4, mux_1, mux_2, mux_3, mux_4}, 8'hF0);
    check("load1_act_ready", act_ready, 1'b0);
    @(negedge clk);
    act_valid = 1'b0;
    act_last  = 1'b0;
    check("stream_entry_ctrl", {act_ready, WE_1, WE_2, WE_3, WE_4, mux_1, mux_2, mux_3, mux_4}, 9'h10F);
    check("stream_entry_top", {top_1, top_2}, '0);
  endtask

  // Offer one activation vector; expected results come from plain dot products.
  task automatic send_vec(input logic [DW-1:0] x0, x1, input bit last);
    int guard = 0;
    int e;
    int unsigned d1, d2;
    act_data  = {x1, x0};
    act_valid = 1'b1;
    act_last  = last;
    while (act_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("act_ready_wait", act_ready, 1'b1);
    if (act_ready === 1'b1) begin
      e  = ecnt + 1;
      d1 = x0 * cw00 + x1 * cw10;
      d2 = x0 * cw01 + x1 * cw11;
      exp_l1[e]     = x0;
      exp_l2[e + 1] = x1;
      q1.push_back('{cyc: e + 2, val: DW'(d1)});
      q2.push_back('{cyc: e + 3, val: DW'(d2)});
      if (last) exp_done = e + 4;
    end
    @(negedge clk);
    act_valid = 1'b0;
    act_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    act_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic random_session(input int max_vecs);
    int n;
    n = $urandom_range(1, max_vecs);
    load(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), 1'b0);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) idle_cycle();
      send_vec(DW'($urandom), DW'($urandom), i == n - 1);
    end
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    w_data    = '0;
    w_valid   = 1'b0;
    act_data  = '0;
    act_valid = 1'b0;
    act_last  = 1'b0;

    repeat (3) @(negedge clk);
    check_outputs("in_reset", 14'b0);
    reset = 1'b1;
    @(negedge clk);
    check_outputs("after_release", 14'b00000000000010);

    // Known weights and a single vector: down_1 = 26, down_2 = 38.
    load(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
    send_vec(16'd5, 16'd7, 1'b1);
    wait_done();
    @(negedge clk);

    // Three vectors with a bubble before the third; next set held through the drain.
    load(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), 1'b0);
    send_vec(DW'($urandom), DW'($urandom), 1'b0);
    send_vec(DW'($urandom), DW'($urandom), 1'b0);
    idle_cycle();
    send_vec(DW'($urandom), DW'($urandom), 1'b1);

    // Wrap-around: 0x8000*2 + 0x8000*2 = 0x20000 -> 0x0000.
    load(16'h8000, DW'($urandom), 16'h8000, DW'($urandom), 1'b1);
    send_vec(16'd2, 16'd2, 1'b1);
    wait_done();

    for (int s = 0; s < 4; s++) begin
      random_session(6);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of a stream clears everything at once.
    load(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), 1'b0);
    send_vec(DW'($urandom), DW'($urandom), 1'b0);
    send_vec(DW'($urandom), DW'($urandom), 1'b0);
    #2;
    reset = 1'b0;
    clear_scoreboard();
    #1;
    check_outputs("mid_stream_reset", 14'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs("after_mid_reset", 14'b00000000000010);

    random_session(4);
    repeat (6) @(negedge clk);
    check("col1_queue_empty", q1.size(), 0);
    check("col2_queue_empty", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
